// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel: fetch stage is master, memory is slave.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 16
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rd;
    logic [17:0]         imem_data;
    logic                imem_valid;

    modport master (output imem_addr, output imem_rd, input imem_data, input imem_valid);
    modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_valid);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC, instruction register and circular return-address stack.
// Define IFETCH_PERF_EN to build the cycle / retired-instruction counters.
module instr_fetch #(
    parameter int                  PC_WIDTH  = 16,
    parameter int                  RAS_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_if.master       imem,
    input  logic                stall,
    input  logic                pc_inc,
    input  logic                pc_jump,
    input  logic                pc_call,
    input  logic                pc_ret,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [17:0]         instruction,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ras_overflow,
    output logic                ras_underflow,
    output logic [31:0]         perf_cycles,
    output logic [31:0]         perf_retired
);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic {FETCH, EXEC} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus1;
    logic [17:0]         instr_q, instr_d;
    logic                vld_q, vld_d;
    logic                rd_q, rd_d;
    logic [PW-1:0]       ptr_q, ptr_d, ptr_m1;
    logic [PW:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                push, exec_done;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];

    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign ptr_m1   = ptr_q - PW'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        vld_d     = vld_q;
        rd_d      = rd_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push      = 1'b0;
        exec_done = 1'b0;
        if (state_q == FETCH) begin
            // A response only counts once our own request is on the bus, so a
            // late reply to a request aborted by reset is dropped.
            if (!rd_q) begin
                rd_d = 1'b1;
            end else if (imem.imem_valid) begin
                instr_d = imem.imem_data;
                vld_d   = 1'b1;
                rd_d    = 1'b0;
                state_d = EXEC;
            end
        end else if (!stall) begin
            exec_done = 1'b1;
            vld_d     = 1'b0;
            rd_d      = 1'b1;
            state_d   = FETCH;
            pc_d      = pc_plus1;
            if (pc_ret) begin
                if (cnt_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d = ptr_m1;
                    cnt_d = cnt_q - (PW+1)'(1);
                    pc_d  = ras_q[ptr_m1];
                end
            end else if (pc_call) begin
                // When full the pointer sits on the oldest entry, so the push overwrites it.
                push  = 1'b1;
                ptr_d = ptr_q + PW'(1);
                pc_d  = jump_addr;
                if (cnt_q == (PW+1)'(RAS_DEPTH)) ovf_d = 1'b1;
                else                              cnt_d = cnt_q + (PW+1)'(1);
            end else if (pc_jump) begin
                pc_d = jump_addr;
            end else if (pc_inc) begin
                pc_d = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            vld_q   <= 1'b0;
            rd_q    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) ras_q[ptr_q] <= pc_plus1;
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] cyc_q, ret_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (exec_done) ret_q <= ret_q + 32'd1;
        end
    end
    assign perf_cycles  = cyc_q;
    assign perf_retired = ret_q;
`else
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

    assign imem.imem_addr = pc_q;
    assign imem.imem_rd   = rd_q;
    assign instruction    = instr_q;
    assign instr_valid    = vld_q;
    assign pc             = pc_q;
    assign ras_overflow   = ovf_q;
    assign ras_underflow  = unf_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, call/ret, RAS limits, wrap, stall, reset abort.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, pc_inc = 1'b0, pc_jump = 1'b0, pc_call = 1'b0, pc_ret = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [17:0] instruction;
    logic        instr_valid;
    logic [15:0] pc;
    logic        ras_overflow, ras_underflow;
    logic [31:0] perf_cycles, perf_retired;
    logic [15:0] cur;
    int          n_vec = 0, n_err = 0, cyc = 0, last_rd_cyc = -1, retired = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_if #(.PC_WIDTH(16)) imem ();

    instr_fetch dut (
        .clk(clk), .reset(reset), .imem(imem),
        .stall(stall), .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_call(pc_call), .pc_ret(pc_ret),
        .jump_addr(jump_addr), .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
        .perf_cycles(perf_cycles), .perf_retired(perf_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // op: 0 none, 1 inc, 2 jump, 3 call, 4 ret, 5 call+ret
    task automatic do_instr(input logic [15:0] addr, input logic [17:0] data, input int op,
                            input logic [15:0] ja, input int nstall, input bit spacing);
        int t = 0;
        while (imem.imem_rd !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (imem.imem_rd !== 1'b1) begin
            chk("rd_timeout", 32'd0, 32'd1);
            return;
        end
        if (spacing && last_rd_cyc >= 0) chk("cyc_per_instr", cyc - last_rd_cyc, 32'd3);
        last_rd_cyc = cyc;
        chk("imem_addr", {16'h0, imem.imem_addr}, {16'h0, addr});
        @(negedge clk);
        imem.imem_valid = 1'b1;
        imem.imem_data  = data;
        @(negedge clk);
        imem.imem_valid = 1'b0;
        imem.imem_data  = '0;
        chk("instr", {14'h0, instruction}, {14'h0, data});
        chk("instr_valid", {31'h0, instr_valid}, 32'd1);
        chk("pc", {16'h0, pc}, {16'h0, addr});
        chk("rd_in_exec", {31'h0, imem.imem_rd}, 32'd0);
        for (int s = 0; s < nstall; s++) begin
            stall     = 1'b1;
            pc_jump   = s[0];
            jump_addr = 16'hBEEF;
            @(negedge clk);
            chk("stall_instr", {14'h0, instruction}, {14'h0, data});
            chk("stall_pc", {16'h0, pc}, {16'h0, addr});
            chk("stall_vld", {31'h0, instr_valid}, 32'd1);
            chk("stall_rd", {31'h0, imem.imem_rd}, 32'd0);
        end
        stall     = 1'b0;
        jump_addr = ja;
        pc_inc    = (op == 1);
        pc_jump   = (op == 2);
        pc_call   = (op == 3 || op == 5);
        pc_ret    = (op == 4 || op == 5);
        @(negedge clk);
        {pc_inc, pc_jump, pc_call, pc_ret} = '0;
        retired++;
        chk("vld_after_exec", {31'h0, instr_valid}, 32'd0);
    endtask

    initial begin
        imem.imem_valid = 1'b0;
        imem.imem_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_rd", {31'h0, imem.imem_rd}, 32'd0);
        chk("rst_vld", {31'h0, instr_valid}, 32'd0);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_instr", {14'h0, instruction}, 32'h0);
        chk("rst_flags", {30'h0, ras_overflow, ras_underflow}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) do_instr(16'(i), 18'h10000 + 18'(i), 1, 16'h0, 0, 1'b1);

        do_instr(16'h0004, 18'h00004, 2, 16'h0010, 0, 1'b0);
        do_instr(16'h0010, 18'h00010, 3, 16'h0200, 0, 1'b0);
        do_instr(16'h0200, 18'h00200, 4, 16'h0, 0, 1'b0);
        do_instr(16'h0011, 18'h00011, 2, 16'h1000, 0, 1'b0);
        chk("call_ret_flags", {30'h0, ras_overflow, ras_underflow}, 32'h0);

        for (int i = 0; i < 9; i++)
            do_instr(16'(16'h1000 + 16'h100 * i), 18'h2_0000 + 18'(i), 3,
                     16'(16'h1000 + 16'h100 * (i + 1)), 0, 1'b0);
        chk("ovf_set", {31'h0, ras_overflow}, 32'd1);
        chk("unf_clear", {31'h0, ras_underflow}, 32'd0);
        cur = 16'h1900;
        for (int k = 0; k < 8; k++) begin
            do_instr(cur, 18'h3_0000 + 18'(k), 4, 16'h0, 0, 1'b0);
            cur = 16'(16'h1000 + 16'h100 * (8 - k) + 1);
        end
        chk("unf_before_9th", {31'h0, ras_underflow}, 32'd0);
        do_instr(cur, 18'h3_0100, 4, 16'h0, 0, 1'b0);
        chk("unf_set", {31'h0, ras_underflow}, 32'd1);

        do_instr(16'h1102, 18'h0_1102, 2, 16'hFFFF, 0, 1'b0);
        do_instr(16'hFFFF, 18'h3_FFFF, 1, 16'h0, 0, 1'b0);
        do_instr(16'h0000, 18'h0_5555, 2, 16'h0300, 5, 1'b0);
        do_instr(16'h0300, 18'h0_0300, 3, 16'h0400, 0, 1'b0);
        do_instr(16'h0400, 18'h0_0400, 5, 16'h0500, 0, 1'b0);
        do_instr(16'h0301, 18'h0_0301, 4, 16'h0, 0, 1'b0);
        do_instr(16'h0302, 18'h0_0302, 0, 16'h0, 0, 1'b0);

        while (imem.imem_rd !== 1'b1 && cyc < 5000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rd", {31'h0, imem.imem_rd}, 32'd0);
        chk("abort_pc", {16'h0, pc}, 32'h0);
        chk("abort_flags", {30'h0, ras_overflow, ras_underflow}, 32'h0);
        reset           = 1'b0;
        retired         = 0;
        imem.imem_valid = 1'b1;
        imem.imem_data  = 18'h3_DEAD;
        @(negedge clk);
        imem.imem_valid = 1'b0;
        imem.imem_data  = '0;
        chk("stale_instr", {14'h0, instruction}, 32'h0);
        chk("stale_vld", {31'h0, instr_valid}, 32'd0);
        chk("refetch_rd", {31'h0, imem.imem_rd}, 32'd1);
        chk("refetch_addr", {16'h0, imem.imem_addr}, 32'h0);
        do_instr(16'h0000, 18'h0_0AAA, 1, 16'h0, 0, 1'b0);
        do_instr(16'h0001, 18'h0_0BBB, 1, 16'h0, 0, 1'b0);
`ifdef IFETCH_PERF_EN
        chk("perf_retired", perf_retired, 32'(retired));
`else
        chk("perf_cycles_tied", perf_cycles, 32'h0);
        chk("perf_retired_tied", perf_retired, 32'h0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of the control decoder.
- Owns the program counter (PC) and the instruction register that drives the decoder's 18-bit instruction input.
- Owns a hardware return-address stack (RAS) for CALL/RET.
- Performs a valid-handshaked read from instruction memory, then holds the instruction stable for one execute cycle and selects the next PC from the decoder's PC-control strobes.

Parameters:
- PC_WIDTH, 16, width of PC and instruction-memory address.
- RAS_DEPTH, 8, number of return-address stack entries; power of two, at least 2.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  PC_WIDTH  instruction-memory read address.
- imem_rd  output  1  read request; held high until imem_valid.
- imem_data  input  18  instruction word from memory.
- imem_valid  input  1  imem_data is valid this cycle.
- stall  input  1  hold the current instruction in EXEC.
- pc_inc  input  1  next PC = PC+1.
- pc_jump  input  1  next PC = jump_addr (taken jump).
- pc_call  input  1  push PC+1, then next PC = jump_addr.
- pc_ret  input  1  next PC = popped RAS entry.
- jump_addr  input  PC_WIDTH  jump/call target.
- instruction  output  18  instruction register, to the decoder.
- instr_valid  output  1  instruction is valid; high only in EXEC.
- pc  output  PC_WIDTH  PC of the held instruction.
- ras_overflow  output  1  sticky: push while RAS full.
- ras_underflow  output  1  sticky: pop while RAS empty.
- perf_cycles  output  32  cycle counter (optional feature).
- perf_retired  output  32  retired-instruction counter (optional feature).

Behaviour:
- Reset (sampled on clk edge):
  - pc=RESET_PC; instruction=0; instr_valid=0; imem_rd=0.
  - RAS pointer=0, RAS count=0; ras_overflow=0, ras_underflow=0; perf counters=0.
  - State = FETCH.
  - Reset asserted mid-fetch or mid-EXEC aborts the operation; any later imem_valid belonging to the aborted request is ignored.
- State FETCH:
  - imem_rd=1 and imem_addr=pc for the first cycle after reset release; imem_rd stays high until imem_valid.
  - On imem_valid: instruction<=imem_data, instr_valid<=1, state<=EXEC.
  - imem_valid in the same cycle as the first imem_rd is legal, giving a 2-cycle minimum per instruction.
- State EXEC:
  - instruction and pc are held stable; imem_rd=0.
  - If stall=1: remain in EXEC; PC strobes are ignored; instr_valid stays 1.
  - Else, next PC by priority pc_ret > pc_call > pc_jump > pc_inc. No strobe asserted selects PC+1.
  - Then instr_valid<=0, state<=FETCH, and the next imem_rd is issued the following cycle.
- imem_valid outside FETCH is ignored.
- Arithmetic: PC+1 is modulo 2^PC_WIDTH, so 16'hFFFF wraps to 16'h0000.
- RAS push (pc_call):
  - Writes PC+1 at the pointer; pointer increments modulo RAS_DEPTH.
  - If count==RAS_DEPTH, the oldest entry is overwritten, count stays saturated, and ras_overflow<=1.
- RAS pop (pc_ret):
  - Pointer decrements and the entry is read.
  - If count==0: next PC = PC+1, pointer unchanged, ras_underflow<=1.
- Simultaneous pc_call and pc_ret: only the RET is performed (priority rule); no push occurs.
- The sticky flags clear only on reset.

Optional Feature:
- IFETCH_PERF_EN defined:
  - perf_cycles increments every non-reset cycle, wrapping at 2^32.
  - perf_retired increments once per EXEC exit (not during stalls).
- Not defined: both counter ports are tied to 0 and no counter registers are synthesized.

Test Plan:
- Reset, RESET_PC=0, memory returns imem_valid 1 cycle after imem_rd, pc_inc every EXEC -> imem_addr sequence 0,1,2,3; instr_valid high for exactly 1 cycle per instruction; 3 cycles per instruction.
- Execute at pc=16'h0010 with pc_call, jump_addr=16'h0200; later pc_ret -> fetches 0x0200, then 0x0011; ras_overflow=0, ras_underflow=0.
- 9 nested calls with RAS_DEPTH=8, then 9 returns -> ras_overflow=1; first 8 returns land at the correct addresses in LIFO order; 9th return sets ras_underflow=1 and fetches PC+1.
- pc=16'hFFFF with pc_inc -> next imem_addr=16'h0000.
- stall=1 for 5 cycles in EXEC while pc_jump toggles -> instruction and pc unchanged, no imem_rd; jump taken only on the first cycle with stall=0.
- Reset asserted while imem_rd is pending, imem_valid arrives 1 cycle after reset release -> stale data discarded; first fetch is from RESET_PC; instr_valid=0 until the new imem_valid.
